// File: rtl/phy_serial_rx_sync.sv
// Single-lane serial-to-parallel receiver with comma (COM) alignment.
// Hunts for COM at any bit offset, locks byte boundaries after COM_THRESH
// consecutive aligned COMs, then emits one tagged byte every 8 clocks.
module phy_serial_rx_sync #(
  parameter logic [7:0]  COM        = 8'hBC,
  parameter logic [7:0]  IDLE       = 8'h7C,
  parameter int unsigned COM_THRESH = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic [1:0] lane_out,
  output logic       strobe_out,
  output logic       active
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ALIGNED = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  localparam logic [3:0] THRESH = COM_THRESH[3:0];

  state_t     state_r, state_s;
  logic [7:0] sr_r;
  logic [7:0] nsr_s;
  logic [2:0] bit_cnt_r, bit_cnt_s;
  logic [3:0] com_cnt_r, com_cnt_s;
  logic [3:0] com_inc_s;
  logic [1:0] lane_cnt_r, lane_cnt_s;
  logic [7:0] data_s;
  logic       valid_s;
  logic [1:0] lane_s;
  logic       strobe_s;
  logic       active_s;
  logic       boundary_s;
  logic       is_com_s;

  // Next-state, counters and next output values for the alignment FSM.
  always_comb begin
    nsr_s      = {sr_r[6:0], data_in};
    boundary_s = (bit_cnt_r == 3'd7);
    is_com_s   = (nsr_s == COM);
    com_inc_s  = com_cnt_r + 4'd1;
    state_s    = state_r;
    bit_cnt_s  = bit_cnt_r;
    com_cnt_s  = com_cnt_r;
    lane_cnt_s = lane_cnt_r;
    data_s     = data_out;
    valid_s    = valid_out;
    lane_s     = lane_out;
    strobe_s   = 1'b0;
    active_s   = active;
    case (state_r)
      SEARCH: begin
        // Bit-granular hunt: the counter is parked until a COM lines up.
        bit_cnt_s = 3'd0;
        if (is_com_s) begin
          com_cnt_s = 4'd1;
          if (THRESH == 4'd1) begin
            state_s    = ACTIVE;
            active_s   = 1'b1;
            lane_cnt_s = 2'd0;
          end else begin
            state_s = ALIGNED;
          end
        end else begin
          state_s   = SEARCH;
          com_cnt_s = 4'd0;
        end
      end
      ALIGNED: begin
        bit_cnt_s = bit_cnt_r + 3'd1;
        if (boundary_s) begin
          if (is_com_s) begin
            com_cnt_s = com_inc_s;
            if (com_inc_s == THRESH) begin
              state_s    = ACTIVE;
              active_s   = 1'b1;
              lane_cnt_s = 2'd0;
            end else begin
              state_s = ALIGNED;
            end
          end else begin
            // Misaligned or broken comma run: drop the byte and re-hunt.
            state_s   = SEARCH;
            com_cnt_s = 4'd0;
            bit_cnt_s = 3'd0;
          end
        end else begin
          state_s = ALIGNED;
        end
      end
      ACTIVE: begin
        bit_cnt_s = bit_cnt_r + 3'd1;
        if (boundary_s) begin
          data_s     = nsr_s;
          valid_s    = (nsr_s != COM) && (nsr_s != IDLE);
          lane_s     = lane_cnt_r;
          lane_cnt_s = lane_cnt_r + 2'd1;
          strobe_s   = 1'b1;
        end else begin
          strobe_s = 1'b0;
        end
      end
      default: begin
        state_s    = SEARCH;
        bit_cnt_s  = 3'd0;
        com_cnt_s  = 4'd0;
        lane_cnt_s = 2'd0;
        active_s   = 1'b0;
      end
    endcase
  end

  // State, shift register, counters and registered outputs.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_r    <= SEARCH;
      sr_r       <= 8'h00;
      bit_cnt_r  <= 3'd0;
      com_cnt_r  <= 4'd0;
      lane_cnt_r <= 2'd0;
      data_out   <= 8'h00;
      valid_out  <= 1'b0;
      lane_out   <= 2'd0;
      strobe_out <= 1'b0;
      active     <= 1'b0;
    end else begin
      state_r    <= state_s;
      sr_r       <= nsr_s;
      bit_cnt_r  <= bit_cnt_s;
      com_cnt_r  <= com_cnt_s;
      lane_cnt_r <= lane_cnt_s;
      data_out   <= data_s;
      valid_out  <= valid_s;
      lane_out   <= lane_s;
      strobe_out <= strobe_s;
      active     <= active_s;
    end
  end

endmodule

// File: tb/tb_phy_serial_rx_sync.sv
// Directed self-checking bench for phy_serial_rx_sync.
module tb_phy_serial_rx_sync;

  logic       clk_32f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] lane_out;
  logic       strobe_out;
  logic       active;

  int vectors;
  int errors;
  int strobe_cnt;

  phy_serial_rx_sync dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .lane_out   (lane_out),
    .strobe_out (strobe_out),
    .active     (active)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  // One serial bit per clock; outputs are observed 1 time unit after the edge.
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
    if (strobe_out === 1'b1) strobe_cnt++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      data_in = i[0];
      @(posedge clk_32f);
      #1;
    end
    reset = 1'b0;
    strobe_cnt = 0;
  endtask

  task automatic lock4();
    for (int i = 0; i < 4; i++) send_byte(8'hBC);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = i[0];
      @(posedge clk_32f);
      #1;
      vectors++;
      if ({data_out, valid_out, lane_out, strobe_out, active} !== 13'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got data=%h valid=%b lane=%0d strobe=%b active=%b, want all 0",
                 i, data_out, valid_out, lane_out, strobe_out, active);
      end
    end
    reset = 1'b0;
    strobe_cnt = 0;
  endtask

  task automatic test_lock_offset();
    do_reset(1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hBC);
      vectors++;
      if (active !== 1'b0) begin
        errors++;
        $display("FAIL lock_early com %0d: active=%b want 0", i + 1, active);
      end
    end
    send_byte(8'hBC);
    vectors++;
    if (active !== 1'b1) begin
      errors++;
      $display("FAIL lock_active: active=%b want 1", active);
    end
    vectors++;
    if (strobe_cnt !== 0 || strobe_out !== 1'b0) begin
      errors++;
      $display("FAIL lock_no_strobe: strobes=%0d strobe_out=%b want 0/0", strobe_cnt, strobe_out);
    end
  endtask

  task automatic test_payload();
    logic [7:0] bytes [5];
    logic       vals  [5];
    logic [1:0] lanes [5];
    bytes = '{8'hA5, 8'h3C, 8'hBC, 8'h7C, 8'h01};
    vals  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    lanes = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int k = 0; k < 5; k++) begin
      send_byte(bytes[k]);
      vectors++;
      if (strobe_out !== 1'b1 || strobe_cnt !== k + 1 || data_out !== bytes[k] ||
          valid_out !== vals[k] || lane_out !== lanes[k]) begin
        errors++;
        $display("FAIL payload byte %0d: got strobe=%b cnt=%0d data=%h valid=%b lane=%0d, want 1/%0d/%h/%b/%0d",
                 k, strobe_out, strobe_cnt, data_out, valid_out, lane_out,
                 k + 1, bytes[k], vals[k], lanes[k]);
      end
    end
    send_bit(1'b0);
    vectors++;
    if (strobe_out !== 1'b0 || data_out !== 8'h01 || valid_out !== 1'b1 || lane_out !== 2'd0) begin
      errors++;
      $display("FAIL payload_hold: got strobe=%b data=%h valid=%b lane=%0d, want 0/01/1/0",
               strobe_out, data_out, valid_out, lane_out);
    end
  endtask

  task automatic test_failed_align();
    do_reset(1);
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h12);
    vectors++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL failalign_after12: active=%b want 0", active);
    end
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    vectors++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL failalign_3com: active=%b want 0", active);
    end
    send_byte(8'hBC);
    vectors++;
    if (active !== 1'b1 || strobe_cnt !== 0) begin
      errors++;
      $display("FAIL failalign_4com: active=%b strobes=%0d want 1/0", active, strobe_cnt);
    end
  endtask

  task automatic test_embedded_comma();
    do_reset(1);
    send_byte(8'h5E);
    send_byte(8'h00);
    send_byte(8'h00);
    vectors++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL embedded_active: active=%b want 0", active);
    end
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    vectors++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL embedded_3com: active=%b want 0", active);
    end
    send_byte(8'hBC);
    vectors++;
    if (active !== 1'b1 || strobe_cnt !== 0) begin
      errors++;
      $display("FAIL embedded_relock: active=%b strobes=%0d want 1/0", active, strobe_cnt);
    end
  endtask

  task automatic test_reset_mid_active();
    logic [7:0] b;
    do_reset(1);
    lock4();
    send_byte(8'hA5);
    vectors++;
    if (strobe_out !== 1'b1 || data_out !== 8'hA5 || lane_out !== 2'd0) begin
      errors++;
      $display("FAIL midreset_pre: strobe=%b data=%h lane=%0d want 1/a5/0", strobe_out, data_out, lane_out);
    end
    b = 8'h3C;
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
    reset = 1'b1;
    send_bit(b[0]);
    reset = 1'b0;
    vectors++;
    if ({data_out, valid_out, lane_out, strobe_out, active} !== 13'd0) begin
      errors++;
      $display("FAIL midreset_clear: data=%h valid=%b lane=%0d strobe=%b active=%b want all 0",
               data_out, valid_out, lane_out, strobe_out, active);
    end
    strobe_cnt = 0;
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    vectors++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL midreset_3com: active=%b want 0", active);
    end
    send_byte(8'hBC);
    vectors++;
    if (active !== 1'b1) begin
      errors++;
      $display("FAIL midreset_relock: active=%b want 1", active);
    end
    send_byte(8'h11);
    vectors++;
    if (strobe_out !== 1'b1 || strobe_cnt !== 1 || data_out !== 8'h11 ||
        valid_out !== 1'b1 || lane_out !== 2'd0) begin
      errors++;
      $display("FAIL midreset_first: strobe=%b cnt=%0d data=%h valid=%b lane=%0d want 1/1/11/1/0",
               strobe_out, strobe_cnt, data_out, valid_out, lane_out);
    end
  endtask

  initial begin
    vectors    = 0;
    errors     = 0;
    strobe_cnt = 0;
    reset      = 1'b1;
    data_in    = 1'b0;
    test_reset();
    test_lock_offset();
    test_payload();
    test_failed_align();
    test_embedded_comma();
    test_reset_mid_active();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
